// File: rtl/aether_pifo_sorted_array.sv
// Purpose  : register-array PIFO holding up to DEPTH {meta, rank} entries sorted by rank
//            (stable among equal ranks), head always in slot 0.
// Latency  : one edge; a pushed entry is visible at the head the cycle after its push edge.
// Backpress: o_ready = ~o_full is advisory. Push while full without a pop is dropped (o_drop).
//            With AETHER_PIFO_EVICT_EN, the tail is evicted instead when the new rank beats it.
//            Push+pop in the same cycle is always accepted, even when full.
//
// Ports:
//   i_clk, i_rst_n      clock, synchronous active-low reset
//   i_push, i_data      push request, {meta[MTW], rank[PTW]}
//   o_ready             ~o_full
//   i_pop               pop request, takes the head when o_valid
//   o_valid, o_data     head entry (registered, 0 when empty)
//   o_count             occupancy, o_full / o_empty derived from it
//   o_drop              high in any cycle whose push discards an entry
//
// Optional feature macro: AETHER_PIFO_EVICT_EN (tail eviction on push while full).

module aether_pifo_sorted_array #(
    parameter int PTW       = 16,
    parameter int MTW       = 32,
    parameter int DEPTH     = 8,
    parameter int MIN_FIRST = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_push,
    input  logic [MTW+PTW-1:0]         i_data,
    output logic                       o_ready,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [MTW+PTW-1:0]         o_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty,
    output logic                       o_drop
);

    localparam int W  = MTW + PTW;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]     slot_q [DEPTH];
    logic [W-1:0]     slot_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    count_q, count_d;

    // Array as it looks after the (optional) pop, and that array shifted down by one.
    logic [W-1:0]     post    [DEPTH];
    logic [W-1:0]     post_sh [DEPTH];
    logic [DEPTH-1:0] post_vld, post_sh_vld;

    logic             full;
    logic             pop_ok;
    logic             push_ok;
    logic             evict_ok;
    logic [CW-1:0]    ins_pos;
    logic [PTW-1:0]   new_rank;

    // Strict rank ordering in the configured direction (unsigned).
    function automatic logic better(input logic [PTW-1:0] a, input logic [PTW-1:0] b);
        if (MIN_FIRST != 0) return a < b;
        else                return a > b;
    endfunction

    always_comb begin
        new_rank = i_data[PTW-1:0];
        full     = (count_q == CW'(DEPTH));
        pop_ok   = i_pop & vld_q[0];

`ifdef AETHER_PIFO_EVICT_EN
        evict_ok = i_push & full & ~pop_ok & better(new_rank, slot_q[DEPTH-1][PTW-1:0]);
`else
        evict_ok = 1'b0;
`endif
        push_ok  = i_push & (~full | pop_ok | evict_ok);

        // Post-pop view: shift everything up one slot; vacated slots read as zero.
        for (int i = 0; i < DEPTH - 1; i++) begin
            post[i]     = pop_ok ? slot_q[i+1] : slot_q[i];
            post_vld[i] = pop_ok ? vld_q[i+1]  : vld_q[i];
        end
        post[DEPTH-1]     = pop_ok ? '0   : slot_q[DEPTH-1];
        post_vld[DEPTH-1] = pop_ok ? 1'b0 : vld_q[DEPTH-1];

        post_sh[0]     = '0;
        post_sh_vld[0] = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            post_sh[i]     = post[i-1];
            post_sh_vld[i] = post_vld[i-1];
        end

        // Insert before the first slot the new rank strictly beats (or the first empty
        // slot), so an equal rank lands behind existing ones. On eviction the old tail
        // simply falls off the end of the shifted array.
        ins_pos = CW'(DEPTH);
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!post_vld[i] || better(new_rank, post[i][PTW-1:0])) ins_pos = CW'(i);
        end

        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = post[i];
            vld_d[i]  = post_vld[i];
            if (push_ok) begin
                if (CW'(i) == ins_pos) begin
                    slot_d[i] = i_data;
                    vld_d[i]  = 1'b1;
                end else if (CW'(i) > ins_pos) begin
                    slot_d[i] = post_sh[i];
                    vld_d[i]  = post_sh_vld[i];
                end
            end
        end

        // An eviction replaces the tail, so it does not change occupancy.
        count_d = count_q;
        case ({push_ok & ~evict_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= '0;
            vld_q   <= '0;
            count_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) slot_q[i] <= slot_d[i];
            vld_q   <= vld_d;
            count_q <= count_d;
        end
    end

    assign o_data  = slot_q[0];
    assign o_valid = vld_q[0];
    assign o_count = count_q;
    assign o_full  = full;
    assign o_empty = (count_q == '0);
    assign o_ready = ~full;
    // Any push that meets a full array with no pop discards something: the new entry
    // or, with eviction, the old tail. Suppressed while reset is asserted.
    assign o_drop  = i_rst_n & i_push & full & ~pop_ok;

endmodule

// File: tb/tb_aether_pifo_sorted_array.sv
module tb_aether_pifo_sorted_array;

    localparam int PTW   = 16;
    localparam int MTW   = 32;
    localparam int DEPTH = 4;
    localparam int W     = MTW + PTW;
    localparam int CW    = $clog2(DEPTH + 1);

    logic         clk = 1'b0;
    logic         rst_n, push, pop;
    logic [W-1:0] data;

    // dut_a: smallest rank first, dut_b: largest rank first; both see the same inputs.
    logic          rdy_a, vld_a, full_a, emp_a, drop_a;
    logic [W-1:0]  dat_a;
    logic [CW-1:0] cnt_a;
    logic          rdy_b, vld_b, full_b, emp_b, drop_b;
    logic [W-1:0]  dat_b;
    logic [CW-1:0] cnt_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    aether_pifo_sorted_array #(.PTW(PTW), .MTW(MTW), .DEPTH(DEPTH), .MIN_FIRST(1)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_data(data), .o_ready(rdy_a),
        .i_pop(pop), .o_valid(vld_a), .o_data(dat_a), .o_count(cnt_a), .o_full(full_a),
        .o_empty(emp_a), .o_drop(drop_a)
    );

    aether_pifo_sorted_array #(.PTW(PTW), .MTW(MTW), .DEPTH(DEPTH), .MIN_FIRST(0)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_data(data), .o_ready(rdy_b),
        .i_pop(pop), .o_valid(vld_b), .o_data(dat_b), .o_count(cnt_b), .o_full(full_b),
        .o_empty(emp_b), .o_drop(drop_b)
    );

    // Reference model: entries kept unsorted in arrival order; the head is found by
    // searching for the best rank, earliest arrival winning ties.
    logic [W-1:0] mq   [2][DEPTH];
    int           mcnt [2];

    function automatic logic [W-1:0] mk(input logic [31:0] meta, input logic [15:0] rank);
        return {meta, rank};
    endfunction

    function automatic bit mbetter(input logic [PTW-1:0] a, input logic [PTW-1:0] b, input int m);
        return (m == 0) ? (a < b) : (a > b);
    endfunction

    function automatic int head_idx(input int m);
        int best = 0;
        for (int i = 1; i < mcnt[m]; i++)
            if (mbetter(mq[m][i][PTW-1:0], mq[m][best][PTW-1:0], m)) best = i;
        return best;
    endfunction

    // Last entry in sorted order: worst rank, latest arrival among equal worst ranks.
    function automatic int tail_idx(input int m);
        int w = 0;
        for (int i = 1; i < mcnt[m]; i++)
            if (!mbetter(mq[m][i][PTW-1:0], mq[m][w][PTW-1:0], m)) w = i;
        return w;
    endfunction

    task automatic mremove(input int m, input int idx);
        for (int i = idx; i < mcnt[m] - 1; i++) mq[m][i] = mq[m][i+1];
        mcnt[m] = mcnt[m] - 1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        for (int m = 0; m < 2; m++) begin
            logic [W-1:0] ed;
            ed = (mcnt[m] > 0) ? mq[m][head_idx(m)] : '0;
            chk(m == 0 ? "data_a"  : "data_b",  m == 0 ? dat_a  : dat_b,  ed);
            chk(m == 0 ? "count_a" : "count_b", m == 0 ? cnt_a  : cnt_b,  mcnt[m]);
            chk(m == 0 ? "valid_a" : "valid_b", m == 0 ? vld_a  : vld_b,  mcnt[m] > 0);
            chk(m == 0 ? "empty_a" : "empty_b", m == 0 ? emp_a  : emp_b,  mcnt[m] == 0);
            chk(m == 0 ? "full_a"  : "full_b",  m == 0 ? full_a : full_b, mcnt[m] == DEPTH);
            chk(m == 0 ? "ready_a" : "ready_b", m == 0 ? rdy_a  : rdy_b,  mcnt[m] != DEPTH);
        end
    endtask

    // Called #1 after a rising edge: drives one cycle, checks o_drop mid-cycle,
    // advances the model across the edge and checks the registered outputs.
    task automatic cycle(input bit p, input logic [W-1:0] d, input bit q);
        bit popped;
        push = p; data = d; pop = q;
        @(negedge clk);
        for (int m = 0; m < 2; m++)
            chk(m == 0 ? "drop_a" : "drop_b", m == 0 ? drop_a : drop_b,
                p && (mcnt[m] == DEPTH) && !(q && mcnt[m] > 0));
        @(posedge clk);
        #1;
        for (int m = 0; m < 2; m++) begin
            popped = q && (mcnt[m] > 0);
            if (popped) mremove(m, head_idx(m));
            if (p) begin
                if (mcnt[m] < DEPTH) begin
                    mq[m][mcnt[m]] = d;
                    mcnt[m] = mcnt[m] + 1;
                end
`ifdef AETHER_PIFO_EVICT_EN
                else if (mbetter(d[PTW-1:0], mq[m][tail_idx(m)][PTW-1:0], m)) begin
                    mremove(m, tail_idx(m));
                    mq[m][mcnt[m]] = d;
                    mcnt[m] = mcnt[m] + 1;
                end
`endif
            end
        end
        push = 0; pop = 0;
        check_outputs();
    endtask

    // Reset asserted for one edge while push and pop are also requested.
    task automatic reset_cycle();
        rst_n = 0; push = 1; pop = 1; data = mk($urandom, 16'($urandom));
        @(negedge clk);
        chk("drop_in_reset_a", drop_a, 1'b0);
        chk("drop_in_reset_b", drop_b, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1; push = 0; pop = 0;
        mcnt[0] = 0; mcnt[1] = 0;
        check_outputs();
    endtask

    task automatic fill4();
        cycle(1, mk(32'hA1, 16'd100), 0);
        cycle(1, mk(32'hB2, 16'd50),  0);
        cycle(1, mk(32'hC3, 16'd150), 0);
        cycle(1, mk(32'hD4, 16'd10),  0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH; i++) cycle(0, '0, 1);
    endtask

    initial begin
        rst_n = 0; push = 0; pop = 0; data = '0;
        mcnt[0] = 0; mcnt[1] = 0;
        @(posedge clk);
        #1;
        reset_cycle();

        // Basic ordering, both directions.
        fill4();
        chk("t1_count", cnt_a, 3'd4);
        chk("t1_full",  full_a, 1'b1);
        chk("t1_ready", rdy_a, 1'b0);
        chk("t1_head_min", dat_a, mk(32'hD4, 16'd10));
        chk("t1_head_max", dat_b, mk(32'hC3, 16'd150));
        drain();
        chk("t1_empty", emp_a, 1'b1);
        chk("t1_valid", vld_a, 1'b0);
        chk("t1_data0", dat_a, 48'd0);

        // Stable ties.
        cycle(1, mk(32'h01, 16'd20), 0);
        cycle(1, mk(32'h02, 16'd20), 0);
        cycle(1, mk(32'h03, 16'd20), 0);
        chk("t2_tie_head", dat_a, mk(32'h01, 16'd20));
        for (int i = 0; i < 3; i++) cycle(0, '0, 1);

        // Push while full, no pop.
        fill4();
        cycle(1, mk(32'hE5, 16'd5), 0);
`ifndef AETHER_PIFO_EVICT_EN
        chk("t3_head_kept", dat_a, mk(32'hD4, 16'd10));
`else
        chk("t3_head_evict", dat_a, mk(32'hE5, 16'd5));
`endif
        cycle(1, mk(32'hF6, 16'd200), 0);
        drain();

        // Push+pop while full.
        fill4();
        cycle(1, mk(32'h77, 16'd70), 1);
        chk("t4_count", cnt_a, 3'd4);
        drain();

        // Empty corner cases.
        cycle(0, '0, 1);
        cycle(1, mk(32'h99, 16'd9), 1);
        chk("t5_head", dat_a, mk(32'h99, 16'd9));
        chk("t5_count", cnt_a, 3'd1);
        cycle(0, '0, 1);

        // Mid-operation reset.
        cycle(1, mk(32'h11, 16'd3), 0);
        cycle(1, mk(32'h22, 16'd1), 0);
        cycle(1, mk(32'h33, 16'd2), 0);
        reset_cycle();

        // Randomized traffic with narrow ranks to exercise ties and full/empty edges.
        for (int n = 0; n < 600; n++) begin
            logic [15:0] r;
            r = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 7));
            if (n % 150 == 149) reset_cycle();
            else cycle(($urandom_range(0, 2) != 0), mk($urandom, r), ($urandom_range(0, 1) == 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
